// File: rtl/wb_arbiter_pkg.sv
// wb_arbiter_pkg: constants and types shared by the register-file write-port
// arbiter and its scoreboard.
//   - Register file geometry (address width, word width, register count).
//   - Write-enable and zero-word constants.
//   - Arbiter FSM state encoding (wb_arb_state_t).
//   - sat_inc: saturating increment for the starvation counter.
package wb_arbiter_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_W      = 32;
    localparam int REG_NUM    = 32;
    localparam int CNT_W      = 4;

    localparam logic             WRITE_ENABLE = 1'b1;
    localparam logic [REG_W-1:0] ZERO_WORD    = '0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_FORCE = 2'd2
    } wb_arb_state_t;

    // Counter holds at all-ones instead of wrapping back to zero.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/wb_arbiter_scoreboard.sv
// wb_scoreboard: pending-write tracker for port-B destinations.
//   One pending bit per register (bit 0 is never set). b_issue marks
//   b_issue_addr pending; a completed port-B transfer (b_xfer) clears b_waddr.
//   A set and a clear of the same register in one cycle leaves it pending.
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   b_issue, b_issue_addr  port-B operation issued, its destination
//   b_xfer, b_waddr     port-B transfer completing this cycle, its destination
//   re1/raddr1, re2/raddr2  decode read ports
//   hazard1, hazard2    read port targets a register still waiting on port B
module wb_scoreboard
    import wb_arbiter_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  b_issue,
    input  logic [REG_ADDR_W-1:0] b_issue_addr,
    input  logic                  b_xfer,
    input  logic [REG_ADDR_W-1:0] b_waddr,
    input  logic                  re1,
    input  logic [REG_ADDR_W-1:0] raddr1,
    input  logic                  re2,
    input  logic [REG_ADDR_W-1:0] raddr2,
    output logic                  hazard1,
    output logic                  hazard2
);

    localparam logic [REG_NUM-1:0] REG0_MASK = REG_NUM'(1);

    logic [REG_NUM-1:0] pending;
    logic [REG_NUM-1:0] set_vec;
    logic [REG_NUM-1:0] clr_vec;

    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (b_issue) set_vec[b_issue_addr] = 1'b1;
        if (b_xfer)  clr_vec[b_waddr]      = 1'b1;
    end

    // Clear first, then set, so a same-cycle set wins. Register 0 is masked.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pending <= '0;
        end else begin
            pending <= ((pending & ~clr_vec) | set_vec) & ~REG0_MASK;
        end
    end

    // The register file forwards wdata to same-cycle reads, so a read of the
    // register being written by port B right now is not a hazard.
    assign hazard1 = re1 & pending[raddr1] & ~(b_xfer & (b_waddr == raddr1));
    assign hazard2 = re2 & pending[raddr2] & ~(b_xfer & (b_waddr == raddr2));

endmodule

// File: rtl/wb_arbiter.sv
// wb_arbiter: shares the register file's single write port between the
// pipeline writeback (port A, never stalls) and a long-latency unit (port B,
// valid/ready). A starvation counter forces one pipeline bubble so port B
// always completes.
//
// Port B handshake: b_valid/b_waddr/b_wdata are held stable from the cycle
// b_valid rises until b_ready=1; b_ready is high for exactly the one cycle in
// which the write happens, and the transfer completes on that clock edge.
//
// Optional feature: define WB_ARB_SCOREBOARD_EN to compile in the pending
// scoreboard (wb_scoreboard) that drives hazard1/hazard2. Without it the
// hazards are tied to 0 and b_issue*, re*/raddr* are ignored.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   a_we/a_waddr/a_wdata     pipeline writeback (highest priority)
//   b_valid/b_waddr/b_wdata  port-B result, b_ready accepts it
//   stall_req                registered bubble request to the pipeline
//   b_issue/b_issue_addr     port-B op issued (scoreboard)
//   re1/raddr1, re2/raddr2   decode read ports checked for hazards
//   hazard1, hazard2         decode must stall on that source
//   we/waddr/wdata           register file write port
//   proto_err                sticky: a_we seen while stall_req=1
//   state                    FSM state, for debug/observation
module wb_arbiter
    import wb_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_we,
    input  logic [REG_ADDR_W-1:0] a_waddr,
    input  logic [REG_W-1:0]      a_wdata,
    input  logic                  b_valid,
    input  logic [REG_ADDR_W-1:0] b_waddr,
    input  logic [REG_W-1:0]      b_wdata,
    output logic                  b_ready,
    output logic                  stall_req,
    input  logic                  b_issue,
    input  logic [REG_ADDR_W-1:0] b_issue_addr,
    input  logic                  re1,
    input  logic [REG_ADDR_W-1:0] raddr1,
    input  logic                  re2,
    input  logic [REG_ADDR_W-1:0] raddr2,
    output logic                  hazard1,
    output logic                  hazard2,
    output logic                  we,
    output logic [REG_ADDR_W-1:0] waddr,
    output logic [REG_W-1:0]      wdata,
    output logic                  proto_err,
    output wb_arb_state_t         state
);

    localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(STARVE_LIMIT);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_inc;

    assign cnt_inc = sat_inc(cnt);

    // Write mux: A always wins, B fills otherwise-idle cycles.
    always_comb begin
        we      = 1'b0;
        waddr   = '0;
        wdata   = ZERO_WORD;
        b_ready = 1'b0;
        if (!rst) begin
            if (a_we) begin
                we    = WRITE_ENABLE;
                waddr = a_waddr;
                wdata = a_wdata;
            end else if (b_valid) begin
                we      = WRITE_ENABLE;
                waddr   = b_waddr;
                wdata   = b_wdata;
                b_ready = 1'b1;
            end
        end
    end

    // cnt counts cycles B has been blocked, including the cycle b_valid rose.
    // The bubble is requested on the edge where that count reaches the limit,
    // so stall_req is seen STARVE_LIMIT cycles after b_valid rose.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            stall_req <= 1'b0;
            proto_err <= 1'b0;
        end else begin
            if (a_we && stall_req) proto_err <= 1'b1;
            case (state)
                ST_IDLE: begin
                    if (b_valid && a_we) begin
                        cnt <= CNT_ONE;
                        if (CNT_ONE >= LIMIT) begin
                            state     <= ST_FORCE;
                            stall_req <= 1'b1;
                        end else begin
                            state <= ST_WAIT;
                        end
                    end
                end
                ST_WAIT: begin
                    if (!a_we) begin
                        state <= ST_IDLE;
                        cnt   <= '0;
                    end else begin
                        cnt <= cnt_inc;
                        if (cnt_inc >= LIMIT) begin
                            state     <= ST_FORCE;
                            stall_req <= 1'b1;
                        end
                    end
                end
                ST_FORCE: begin
                    // A pipeline that ignores the stall still wins the port;
                    // keep requesting the bubble until B actually gets it.
                    if (!a_we) begin
                        state     <= ST_IDLE;
                        cnt       <= '0;
                        stall_req <= 1'b0;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    cnt       <= '0;
                    stall_req <= 1'b0;
                end
            endcase
        end
    end

`ifdef WB_ARB_SCOREBOARD_EN
    logic b_xfer;
    logic hz1;
    logic hz2;

    assign b_xfer = b_valid & b_ready;

    wb_scoreboard u_scoreboard (
        .clk          (clk),
        .rst          (rst),
        .b_issue      (b_issue),
        .b_issue_addr (b_issue_addr),
        .b_xfer       (b_xfer),
        .b_waddr      (b_waddr),
        .re1          (re1),
        .raddr1       (raddr1),
        .re2          (re2),
        .raddr2       (raddr2),
        .hazard1      (hz1),
        .hazard2      (hz2)
    );

    assign hazard1 = hz1 & ~rst;
    assign hazard2 = hz2 & ~rst;
`else
    logic unused_sb;

    assign unused_sb = ^{b_issue, b_issue_addr, re1, raddr1, re2, raddr2};
    assign hazard1   = 1'b0;
    assign hazard2   = 1'b0;
`endif

endmodule
